fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 104 ++++++++++
 tb/tb_fetch_queue.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO between a combinational instruction
// memory and the IF/ID register. Fetches one word per cycle while there is
// room, delivers the head entry {instr, pc+4} and flushes on redirect.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   imem_addr         fetch address (current fetch pc)
//   imem_data         instruction word for imem_addr, same cycle
//   stall             downstream holding, head not consumed
//   redirect          flush queue and refetch from redirect_pc
//   redirect_pc       new fetch address
//   instr_out         head instruction, 0 when empty
//   pc_plus4_out      head fetch address + 4, 0 when empty
//   valid_out         head present
//   count             occupied entries
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_data,
  input  logic                     stall,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  output logic [31:0]              instr_out,
  output logic [31:0]              pc_plus4_out,
  output logic                     valid_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc4_mem_q   [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   fpc_plus4;
  logic          pop, push;

  assign fpc_plus4 = fpc_q + 32'd4;  // wraps modulo 2^32

  // Pop frees a slot in the same cycle, so a full queue keeps streaming.
  assign pop  = valid_out & ~stall & ~redirect;
  assign push = ~redirect & ((cnt_q != FULL) | pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    fpc_d    = fpc_q;
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      fpc_d    = redirect_pc;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;  // power-of-two depth: natural wrap
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        fpc_d    = fpc_plus4;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      fpc_q    <= RESET_PC;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      fpc_q    <= fpc_d;
    end
  end

  // Storage is never cleared; count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      instr_mem_q[wr_ptr_q] <= imem_data;
      pc4_mem_q[wr_ptr_q]   <= fpc_plus4;
    end
  end

  assign imem_addr    = fpc_q;
  assign valid_out    = (cnt_q != '0);
  assign count        = cnt_q;
  assign instr_out    = valid_out ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign pc_plus4_out = valid_out ? pc4_mem_q[rd_ptr_q]   : 32'h0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, a wrap-around sequence on a
// second instance, then a randomized run against a queue scoreboard.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] KEY = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc, imem_addr, imem_data, instr_out, pc_plus4_out;
  logic        valid_out;
  logic [2:0]  count;

  logic        rst_w, stall_w, redirect_w;
  logic [31:0] imem_addr_w, imem_data_w, instr_out_w, pc4_w;
  logic        valid_w;
  logic [2:0]  count_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data   = imem_addr ^ KEY;
  assign imem_data_w = imem_addr_w ^ KEY;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .instr_out(instr_out), .pc_plus4_out(pc_plus4_out),
    .valid_out(valid_out), .count(count));

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFFFFF8)) u_wrap (
    .clk(clk), .rst(rst_w), .imem_addr(imem_addr_w), .imem_data(imem_data_w),
    .stall(stall_w), .redirect(redirect_w), .redirect_pc(32'h0),
    .instr_out(instr_out_w), .pc_plus4_out(pc4_w),
    .valid_out(valid_w), .count(count_w));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst, stall, redir;
    logic [31:0] rpc;
    logic        chk, vld;
    logic [2:0]  cnt;
    logic [31:0] addr, pc4, instr;
  } vec_t;

  vec_t vt[17];

  function automatic vec_t mk(logic r, logic s, logic d, logic [31:0] rpc, logic c,
                              logic v, logic [2:0] n, logic [31:0] a, logic [31:0] p,
                              logic [31:0] i);
    vec_t x;
    x.rst = r; x.stall = s; x.redir = d; x.rpc = rpc; x.chk = c;
    x.vld = v; x.cnt = n; x.addr = a; x.pc4 = p; x.instr = i;
    return x;
  endfunction

  typedef struct { logic [31:0] instr, pc4; } ent_t;
  ent_t sb[$];
  logic [31:0] mfpc;

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    rst_w = 1'b1; stall_w = 1'b0; redirect_w = 1'b0;

    // inputs applied this cycle | outputs expected this cycle (before the edge)
    vt[0]  = mk(1,0,0,0,      0, 0,0,0,0,0);
    vt[1]  = mk(0,0,0,0,      1, 0,0,32'h0,  32'h0,  32'h0);
    vt[2]  = mk(0,0,0,0,      1, 1,1,32'h4,  32'h4,  32'hA5A5A5A5);
    vt[3]  = mk(0,1,0,0,      1, 1,1,32'h8,  32'h8,  32'hA5A5A5A1);
    vt[4]  = mk(0,1,0,0,      1, 1,2,32'hC,  32'h8,  32'hA5A5A5A1);
    vt[5]  = mk(0,1,0,0,      1, 1,3,32'h10, 32'h8,  32'hA5A5A5A1);
    vt[6]  = mk(0,1,0,0,      1, 1,4,32'h14, 32'h8,  32'hA5A5A5A1);
    vt[7]  = mk(0,1,1,32'h100,1, 1,4,32'h14, 32'h8,  32'hA5A5A5A1);
    vt[8]  = mk(0,0,0,0,      1, 0,0,32'h100,32'h0,  32'h0);
    vt[9]  = mk(0,1,0,0,      1, 1,1,32'h104,32'h104,32'hA5A5A4A5);
    vt[10] = mk(0,1,0,0,      1, 1,2,32'h108,32'h104,32'hA5A5A4A5);
    vt[11] = mk(1,1,1,32'h200,1, 1,3,32'h10C,32'h104,32'hA5A5A4A5);
    vt[12] = mk(0,0,1,32'h40, 1, 0,0,32'h0,  32'h0,  32'h0);
    vt[13] = mk(0,0,1,32'h80, 1, 0,0,32'h40, 32'h0,  32'h0);
    vt[14] = mk(0,0,0,0,      1, 0,0,32'h80, 32'h0,  32'h0);
    vt[15] = mk(0,0,0,0,      1, 1,1,32'h84, 32'h84, 32'hA5A5A525);
    vt[16] = mk(0,0,0,0,      1, 1,1,32'h88, 32'h88, 32'hA5A5A521);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (vt[i].chk) begin
        chk($sformatf("v%0d.valid", i), {31'h0, valid_out}, {31'h0, vt[i].vld});
        chk($sformatf("v%0d.count", i), {29'h0, count}, {29'h0, vt[i].cnt});
        chk($sformatf("v%0d.addr", i),  imem_addr, vt[i].addr);
        chk($sformatf("v%0d.pc4", i),   pc_plus4_out, vt[i].pc4);
        chk($sformatf("v%0d.instr", i), instr_out, vt[i].instr);
      end
      rst = vt[i].rst; stall = vt[i].stall;
      redirect = vt[i].redir; redirect_pc = vt[i].rpc;
    end

    // Fetch address wrap across 2^32 on the second instance.
    @(negedge clk); rst_w = 1'b0;
    chk("wrap.addr0", imem_addr_w, 32'hFFFFFFF8);
    chk("wrap.valid0", {31'h0, valid_w}, 32'h0);
    @(negedge clk);
    chk("wrap.addr1", imem_addr_w, 32'hFFFFFFFC);
    chk("wrap.pc4_1", pc4_w, 32'hFFFFFFFC);
    chk("wrap.instr1", instr_out_w, 32'hFFFFFFF8 ^ KEY);
    @(negedge clk);
    chk("wrap.addr2", imem_addr_w, 32'h0);
    chk("wrap.pc4_2", pc4_w, 32'h0);
    @(negedge clk);
    chk("wrap.addr3", imem_addr_w, 32'h4);
    chk("wrap.pc4_3", pc4_w, 32'h4);
    chk("wrap.count", {29'h0, count_w}, 32'h1);

    // Randomized run; scoreboard holds entries in program order.
    mfpc = '0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (c > 0) begin
        chk("rnd.valid", {31'h0, valid_out}, {31'h0, sb.size() != 0});
        chk("rnd.count", {29'h0, count}, sb.size());
        chk("rnd.addr", imem_addr, mfpc);
        if (count > DEPTH) chk("rnd.count_max", {29'h0, count}, DEPTH);
        if (sb.size() != 0) begin
          chk("rnd.instr", instr_out, sb[0].instr);
          chk("rnd.pc4", pc_plus4_out, sb[0].pc4);
        end else begin
          chk("rnd.instr0", instr_out, 32'h0);
          chk("rnd.pc4_0", pc_plus4_out, 32'h0);
        end
      end
      rst         = (c == 0) || ($urandom_range(99) == 0);
      stall       = ($urandom_range(9) < 4);
      redirect    = ($urandom_range(19) == 0);
      redirect_pc = {$urandom_range(32'hFFFF), 2'b00} | ($urandom_range(1) ? 32'hFFF00000 : 32'h0);
      if (rst) begin
        sb.delete();
        mfpc = 32'h0;
      end else if (redirect) begin
        sb.delete();
        mfpc = redirect_pc;
      end else begin
        logic p, q;
        ent_t e;
        p = (sb.size() != 0) && !stall;
        q = (sb.size() < DEPTH) || p;
        if (p) void'(sb.pop_front());
        if (q) begin
          e.instr = mfpc ^ KEY;
          e.pc4   = mfpc + 32'd4;
          sb.push_back(e);
          mfpc = mfpc + 32'd4;
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
